psram_arb_ctrl: RTL

Parametrised successor to the single-port cellular-RAM interface. Arbitrates NCH independent request channels, round-robin, onto the board's 16-bit asynchronous PSRAM. Runs full async read/write cycles with configurable wait states, byte enables and a per-channel ack handshake. Sits between on-chip clients (switch/LED debug logic, sample engines) and the MemDB/MemAdr pins.

---
 rtl/psram_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/psram_arb_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/psram_pkg.sv
`default_nettype none
//==============================================================================
// Module   : psram_pkg
// Desc     : Shared constants for the PSRAM arbiter/controller: bus width,
//            FSM state encoding and the inactive levels of the RAM strobes.
// Revision : 1.0 - initial release
//==============================================================================
package psram_pkg;

    // Width of the PSRAM data bus
    localparam int DATA_W = 16;

    // Controller FSM states
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_hold   = 2'd3;

    // Inactive level of the active-low strobes (CS, OE, WR)
    localparam logic       c_strobe_off = 1'b1;
    // Inactive level of the byte-lane strobes {UB, LB}
    localparam logic [1:0] c_lanes_off  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : rr_arbiter
// Desc     : Round-robin arbiter. Combinational grant of the first requesting
//            channel at or after the pointer (wrapping); the pointer moves to
//            the channel after the one served when an operation completes.
// Revision : 1.0 - initial release
//==============================================================================
module rr_arbiter #(
    parameter  int NCH   = 2,
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic             upd,
    input  logic [IDX_W-1:0] upd_idx,
    output logic [NCH-1:0]   grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] r_ptr;

    // Scan from farthest to nearest so the channel closest to the pointer wins
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int off = NCH - 1; off >= 0; off--) begin
            int ch;
            ch = int'(r_ptr) + off;
            if (ch >= NCH) ch = ch - NCH;
            if (req[ch]) begin
                grant_oh     = '0;
                grant_oh[ch] = 1'b1;
                grant_idx    = IDX_W'(ch);
                any          = 1'b1;
            end
        end
    end

    // Pointer advances past the served channel when its operation completes
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (upd) begin
            r_ptr <= (upd_idx == IDX_W'(NCH - 1)) ? '0 : upd_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/psram_arb_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : psram_arb_ctrl
// Desc     : Round-robin arbitration of NCH client channels onto a 16-bit
//            asynchronous PSRAM. Each operation runs SETUP / ACCESS (WAIT_CYC
//            cycles) / HOLD, then one IDLE cycle that doubles as bus turnaround.
//            A one-cycle ack pulse goes to the served channel in HOLD.
// Options  : PSRAM_STAT_EN - adds rd_cnt / wr_cnt completed-operation counters
// Revision : 1.0 - initial release
//==============================================================================
module psram_arb_ctrl
    import psram_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int ADDR_W   = 23,
    parameter int WAIT_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        we,
    input  logic [NCH*ADDR_W-1:0] addr,
    input  logic [NCH*DATA_W-1:0] wdata,
    input  logic [NCH*2-1:0]      be,
    output logic [NCH-1:0]        ack,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
`ifdef PSRAM_STAT_EN
    output logic [15:0]           rd_cnt,
    output logic [15:0]           wr_cnt,
`endif
    inout  wire  [DATA_W-1:0]     MemDB,
    output logic [ADDR_W-1:0]     MemAdr,
    output logic                  MemAdv,
    output logic                  MemClk,
    output logic                  RamCS,
    output logic                  MemOE,
    output logic                  MemWR,
    output logic                  RamLB,
    output logic                  RamUB
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(WAIT_CYC - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_grant_idx;
    logic [NCH-1:0]    r_grant_oh;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_be;
    logic [NCH-1:0]    r_ack;
    logic [DATA_W-1:0] r_rdata;

    logic [NCH-1:0]    w_grant_oh;
    logic [IDX_W-1:0]  w_grant_idx;
    logic              w_any;
    logic              w_in_hold;

    logic [ADDR_W-1:0] w_addr_a  [NCH];
    logic [DATA_W-1:0] w_wdata_a [NCH];
    logic [1:0]        w_be_a    [NCH];

    // Split the packed per-channel buses into indexable arrays
    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign w_addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
        assign w_wdata_a[i] = wdata[i*DATA_W +: DATA_W];
        assign w_be_a[i]    = be[i*2 +: 2];
    end

    assign w_in_hold = (r_state == c_st_hold);

    rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .upd       (w_in_hold),
        .upd_idx   (r_grant_idx),
        .grant_oh  (w_grant_oh),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    // Operation sequencer: latch the granted request, time the strobe window,
    // capture read data on the last ACCESS cycle and pulse ack into HOLD
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_grant_idx <= '0;
            r_grant_oh  <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_grant_idx <= w_grant_idx;
                        r_grant_oh  <= w_grant_oh;
                        r_we        <= we[w_grant_idx];
                        r_addr      <= w_addr_a[w_grant_idx];
                        r_wdata     <= w_wdata_a[w_grant_idx];
                        r_be        <= w_be_a[w_grant_idx];
                        r_state     <= c_st_setup;
                    end
                end
                c_st_setup: begin
                    r_cnt   <= c_cnt_load;
                    r_state <= c_st_access;
                end
                c_st_access: begin
                    if (r_cnt == '0) begin
                        if (!r_we) r_rdata <= MemDB;
                        r_ack   <= r_grant_oh;
                        r_state <= c_st_hold;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_st_hold: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // RAM strobe decode: CS spans SETUP+ACCESS, OE/WR and lanes only in ACCESS
    always_comb begin
        RamCS          = c_strobe_off;
        MemOE          = c_strobe_off;
        MemWR          = c_strobe_off;
        {RamUB, RamLB} = c_lanes_off;
        case (r_state)
            c_st_setup: begin
                RamCS = 1'b0;
            end
            c_st_access: begin
                RamCS = 1'b0;
                if (r_we) begin
                    MemWR = 1'b0;
                    RamLB = ~r_be[0];
                    RamUB = ~r_be[1];
                end else begin
                    MemOE = 1'b0;
                    RamLB = 1'b0;
                    RamUB = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Write data is driven from SETUP through HOLD so it covers setup and hold time
    assign MemDB  = (r_we && (r_state != c_st_idle)) ? r_wdata : {DATA_W{1'bz}};
    assign MemAdr = r_addr;
    assign MemAdv = 1'b0;
    assign MemClk = 1'b0;
    assign ack    = r_ack;
    assign rdata  = r_rdata;
    assign busy   = (r_state != c_st_idle);

`ifdef PSRAM_STAT_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;

    // Count completed operations at ack time, wrapping naturally at 16 bits
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (w_in_hold) begin
            if (r_we) r_wr_cnt <= r_wr_cnt + 16'd1;
            else      r_rd_cnt <= r_rd_cnt + 16'd1;
        end
    end

    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
`endif

endmodule
`default_nettype wire
